// File: rtl/stack_pusher.sv
// 6502 stack push sequencer: writes 1-3 bytes to page STACK_PAGE, post-decrementing SP.
// Define STACK_PUSHER_BRK_FLAG_EN to force bit5=1 and bit4=brk_in_i in the pushed P byte.
module stack_pusher #(
  parameter int unsigned                       REG_WIDTH  = 8,
  parameter int unsigned                       ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-REG_WIDTH-1:0]   STACK_PAGE = 'h01,
  parameter logic [REG_WIDTH-1:0]              SP_RESET   = 'hFD
) (
  input  logic                  phi1_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [REG_WIDTH-1:0]  data_in_i,
  input  logic [ADDR_WIDTH-1:0] pc_in_i,
  input  logic [REG_WIDTH-1:0]  status_in_i,
  input  logic                  brk_in_i,
  input  logic [REG_WIDTH-1:0]  sp_in_i,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [REG_WIDTH-1:0]  data_out_o,
  output logic                  write_en_o,
  output logic [REG_WIDTH-1:0]  sp_out_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] ModeByte = 2'b00;
  localparam logic [1:0] ModePc   = 2'b01;
  localparam logic [1:0] ModeRsvd = 2'b11;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                  state_q;
  logic [1:0]              mode_q;
  logic [1:0]              idx_q;
  logic [REG_WIDTH-1:0]    pcl_q;
  logic [REG_WIDTH-1:0]    p_q;
  logic [REG_WIDTH-1:0]    sp_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [REG_WIDTH-1:0]    data_out_q;
  logic                    write_en_q;
  logic                    busy_q;
  logic                    done_q;

  logic [REG_WIDTH-1:0]    p_in;
  logic [REG_WIDTH-1:0]    first_byte;
  logic [REG_WIDTH-1:0]    next_byte;
  logic [REG_WIDTH-1:0]    sp_dec;
  logic [1:0]              idx_inc;
  logic [1:0]              last_idx;
  logic                    is_last;

  always_comb begin
    p_in = status_in_i;
`ifdef STACK_PUSHER_BRK_FLAG_EN
    p_in[5] = 1'b1;
    p_in[4] = brk_in_i;
`endif
    // Byte 0 comes straight from the inputs since operands are latched on the same edge.
    first_byte = (mode_i == ModeByte) ? data_in_i : pc_in_i[ADDR_WIDTH-1 -: REG_WIDTH];
    sp_dec     = sp_q - REG_WIDTH'(1);
    idx_inc    = idx_q + 2'd1;
    next_byte  = (idx_inc == 2'd1) ? pcl_q : p_q;
    case (mode_q)
      ModeByte: last_idx = 2'd0;
      ModePc:   last_idx = 2'd1;
      default:  last_idx = 2'd2;
    endcase
    is_last = (idx_q == last_idx);
  end

`ifndef STACK_PUSHER_BRK_FLAG_EN
  logic unused_brk;
  assign unused_brk = brk_in_i;
`endif

  always_ff @(posedge phi1_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      mode_q     <= ModeByte;
      idx_q      <= 2'd0;
      pcl_q      <= '0;
      p_q        <= '0;
      sp_q       <= SP_RESET;
      addr_q     <= '0;
      data_out_q <= '0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i && (mode_i != ModeRsvd)) begin
            mode_q     <= mode_i;
            pcl_q      <= pc_in_i[REG_WIDTH-1:0];
            p_q        <= p_in;
            sp_q       <= sp_in_i;
            idx_q      <= 2'd0;
            addr_q     <= {STACK_PAGE, sp_in_i};
            data_out_q <= first_byte;
            write_en_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StWrite;
          end
        end
        StWrite: begin
          if (mem_ready_i) begin
            sp_q  <= sp_dec;
            idx_q <= idx_inc;
            if (is_last) begin
              write_en_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end else begin
              // SP wraps within the page; the high address byte is never touched.
              addr_q     <= {STACK_PAGE, sp_dec};
              data_out_q <= next_byte;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          write_en_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign addr_o     = addr_q;
  assign data_out_o = data_out_q;
  assign write_en_o = write_en_q;
  assign sp_out_o   = sp_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_stack_pusher.sv
// Randomised bench for stack_pusher against a byte-list model of the push sequence.
module tb_stack_pusher;

  logic        phi1_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [7:0]  data_in_i;
  logic [15:0] pc_in_i;
  logic [7:0]  status_in_i;
  logic        brk_in_i;
  logic [7:0]  sp_in_i;
  logic        mem_ready_i;
  logic [15:0] addr_o;
  logic [7:0]  data_out_o;
  logic        write_en_o;
  logic [7:0]  sp_out_o;
  logic        busy_o;
  logic        done_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  exp_sp;

  stack_pusher dut (
    .phi1_i      (phi1_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .data_in_i   (data_in_i),
    .pc_in_i     (pc_in_i),
    .status_in_i (status_in_i),
    .brk_in_i    (brk_in_i),
    .sp_in_i     (sp_in_i),
    .mem_ready_i (mem_ready_i),
    .addr_o      (addr_o),
    .data_out_o  (data_out_o),
    .write_en_o  (write_en_o),
    .sp_out_o    (sp_out_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 phi1_i = ~phi1_i;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] p_model(input logic [7:0] st, input logic brk);
`ifdef STACK_PUSHER_BRK_FLAG_EN
    return (st & 8'hCF) | 8'h20 | (brk ? 8'h10 : 8'h00);
`else
    return brk ? st : st;
`endif
  endfunction

  task automatic scramble();
    data_in_i   = 8'($urandom);
    pc_in_i     = 16'($urandom);
    status_in_i = 8'($urandom);
    brk_in_i    = 1'($urandom);
    sp_in_i     = 8'($urandom);
    mode_i      = 2'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_we"},   32'(write_en_o), 32'd0);
    check_val({tag, "_busy"}, 32'(busy_o),     32'd0);
    check_val({tag, "_done"}, 32'(done_o),     32'd0);
    check_val({tag, "_sp"},   32'(sp_out_o),   32'(exp_sp));
  endtask

  task automatic idle(input int k);
    start_i = 1'b0;
    repeat (k) begin
      scramble();
      mem_ready_i = 1'($urandom);
      @(negedge phi1_i);
      check_idle("idle");
      @(posedge phi1_i); #1;
    end
  endtask

  // Entered and left at posedge+1; on exit the bench sits in the cycle after done.
  task automatic run_push(input logic [1:0] m, input logic [15:0] pc, input logic [7:0] st,
                          input logic [7:0] d, input logic [7:0] sp, input logic brk,
                          input int wmin, input int wmax, input bit noisy, input bit done_start);
    logic [7:0] bytes[$];
    logic [7:0] cur_sp;
    int         n;
    int         w;
    if (m == 2'd0) begin
      bytes.push_back(d);
    end else begin
      bytes.push_back(pc[15:8]);
      bytes.push_back(pc[7:0]);
      if (m == 2'd2) bytes.push_back(p_model(st, brk));
    end
    n = bytes.size();
    start_i = 1'b1; mode_i = m; pc_in_i = pc; status_in_i = st;
    data_in_i = d; sp_in_i = sp; brk_in_i = brk; mem_ready_i = 1'($urandom);
    @(negedge phi1_i);
    check_idle("pre");
    @(posedge phi1_i); #1;
    for (int i = 0; i < n; i++) begin
      cur_sp = sp - 8'(i);
      w = int'($urandom_range(wmax, wmin));
      for (int c = 0; c <= w; c++) begin
        if (noisy) begin
          scramble();
          start_i = 1'($urandom);
        end else begin
          start_i = 1'b0;
        end
        mem_ready_i = (c == w);
        @(negedge phi1_i);
        check_val("wr_we",   32'(write_en_o), 32'd1);
        check_val("wr_busy", 32'(busy_o),     32'd1);
        check_val("wr_done", 32'(done_o),     32'd0);
        check_val("wr_addr", 32'(addr_o),     32'({8'h01, cur_sp}));
        check_val("wr_data", 32'(data_out_o), 32'(bytes[i]));
        check_val("wr_sp",   32'(sp_out_o),   32'(cur_sp));
        @(posedge phi1_i); #1;
      end
    end
    exp_sp = sp - 8'(n);
    start_i = done_start;
    mode_i = 2'($urandom_range(2, 0));
    mem_ready_i = 1'($urandom);
    @(negedge phi1_i);
    check_val("dn_done", 32'(done_o),     32'd1);
    check_val("dn_busy", 32'(busy_o),     32'd0);
    check_val("dn_we",   32'(write_en_o), 32'd0);
    check_val("dn_sp",   32'(sp_out_o),   32'(exp_sp));
    @(posedge phi1_i); #1;
    start_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; mem_ready_i = 1'b0;
    scramble();
    repeat (3) @(posedge phi1_i);
    #1;
    reset_i = 1'b0;
    exp_sp = 8'hFD;
    @(negedge phi1_i);
    check_idle("rst");
    check_val("rst_addr", 32'(addr_o),     32'd0);
    check_val("rst_data", 32'(data_out_o), 32'd0);
    @(posedge phi1_i); #1;

    // JSR with ready tied high
    run_push(2'd1, 16'hC012, 8'h00, 8'h00, 8'hFD, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1);
    check_val("jsr_sp", 32'(sp_out_o), 32'h0000_00FB);

    // Interrupt entry, two wait states per byte
    run_push(2'd2, 16'h8000, 8'hA3, 8'h00, 8'hFF, 1'b1, 2, 2, 1'b0, 1'b0);
    idle(2);
    check_val("int_sp", 32'(sp_out_o), 32'h0000_00FC);

    // SP wrap inside the stack page
    run_push(2'd1, 16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1);
    check_val("wrap_sp", 32'(sp_out_o), 32'h0000_00FE);

    // Reserved mode start is ignored
    start_i = 1'b1; mode_i = 2'b11; sp_in_i = 8'h10;
    @(posedge phi1_i); #1;
    start_i = 1'b0;
    @(negedge phi1_i);
    check_idle("rsvd");
    @(posedge phi1_i); #1;

    // PHA with start noise, start in the done cycle, then back-to-back PHA
    run_push(2'd0, 16'h0000, 8'h00, 8'h55, 8'hFD, 1'b0, 0, 2, 1'b1, 1'b1);
    run_push(2'd0, 16'h0000, 8'h00, 8'hAA, 8'hFC, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1);

    // Reset after the first accepted byte of an interrupt push
    start_i = 1'b1; mode_i = 2'd2; pc_in_i = 16'h8000; status_in_i = 8'hA3;
    sp_in_i = 8'hFF; mem_ready_i = 1'b1;
    @(posedge phi1_i); #1;
    start_i = 1'b0;
    @(posedge phi1_i); #1;
    @(negedge phi1_i);
    check_val("mid_addr", 32'(addr_o), 32'h0000_01FE);
    reset_i = 1'b1;
    @(posedge phi1_i); #1;
    reset_i = 1'b0;
    exp_sp = 8'hFD;
    @(negedge phi1_i);
    check_idle("mid_rst");
    @(posedge phi1_i); #1;
    mem_ready_i = 1'b1;
    idle(3);

    // Randomised sequences
    repeat (60) begin
      run_push(2'($urandom_range(2, 0)), 16'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom), 0, int'($urandom_range(3, 0)),
               1'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(2, 1)));
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_pusher.md
Name: stack_pusher

Overview:
- Multi-byte memory write sequencer; the write-side counterpart of the instruction fetcher.
- Pushes 1–3 bytes onto the 6502 hardware stack at page STACK_PAGE, post-decrementing SP per byte.
- Used for PHA/PHP (1 byte), JSR (PCH, PCL) and BRK/IRQ/NMI entry (PCH, PCL, P).
- Sits between the control unit and the memory write port; reports the updated SP back to the register file.

Parameters:
- REG_WIDTH, 8, data/register width
- ADDR_WIDTH, 16, memory address width
- STACK_PAGE, 8'h01, high address byte of the stack page
- SP_RESET, 8'hFD, SP value after reset

Ports:
- phi1  input  1  clock; all state updates on posedge phi1
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a push sequence; sampled only in IDLE
- mode  input  2  00 BYTE (data_in); 01 PC (PCH, PCL); 10 INT (PCH, PCL, P); 11 reserved
- data_in  input  REG_WIDTH  byte for BYTE mode
- pc_in  input  ADDR_WIDTH  return address for PC/INT modes
- status_in  input  REG_WIDTH  processor status for INT mode
- brk_in  input  1  B-flag source; used only with the optional feature
- sp_in  input  REG_WIDTH  current SP, latched on start
- mem_ready  input  1  memory accepted the write this cycle
- addr  output  ADDR_WIDTH  write address
- data_out  output  REG_WIDTH  write data
- write_en  output  1  write request
- sp_out  output  REG_WIDTH  working/updated SP
- busy  output  1  sequence in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high):
  - Forces state IDLE.
  - Output values: write_en=0, busy=0, done=0, addr=0, data_out=0, sp_out=SP_RESET.
  - Clears the byte index and the latched operands.
- States: IDLE, WRITE, DONE.
- IDLE:
  - If start=1 and mode!=11: latch pc_in, status_in, data_in and mode; load sp_out<=sp_in; set byte index 0; go to WRITE; busy=1.
  - If start=1 and mode=11: ignored; stay IDLE; no outputs change.
- WRITE:
  - Outputs: write_en=1, addr={STACK_PAGE, sp_out}, data_out=current byte.
  - Byte order for PC and INT modes: index0=PCH, index1=PCL, index2=P (INT only).
  - BYTE mode: index0=data_in.
  - On posedge with mem_ready=1: sp_out<=sp_out-1, modulo 256 (8'h00 -> 8'hFF; address stays in STACK_PAGE and never carries into the high byte); index++.
  - If the accepted byte was the last one, go to DONE and drop write_en.
  - With mem_ready=0: hold addr, data_out, write_en and index unchanged (wait states unbounded).
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - sp_out holds its final value until the next start or reset.
- start while busy: ignored; latched operands do not change mid-sequence.
- start in the DONE cycle: ignored. The earliest new start is accepted in the cycle after done.
- Latency with mem_ready tied high and N bytes:
  - start sampled at edge 0.
  - write_en high for cycles 1..N.
  - done in cycle N+1.
- Reset mid-sequence: aborts immediately at that edge. Bytes already accepted stay written; no further write_en; sp_out=SP_RESET.
- Input changes after start: pc_in, status_in and data_in changes have no effect once latched.

Optional Feature:
- Macro: STACK_PUSHER_BRK_FLAG_EN.
- Defined: in INT mode, the pushed P byte is status_in with bit5 forced to 1 and bit4 replaced by brk_in.
- Undefined: P is pushed as status_in unmodified, and brk_in is ignored.
- BYTE and PC modes are identical in both builds.

Test Plan:
- JSR push: sp_in=FD, pc_in=C012, mode=01, mem_ready=1 -> writes 0x01FD<=C0, then 0x01FC<=12; done in cycle 3; sp_out=FB.
- INT push with wait states: sp_in=FF, pc_in=8000, status_in=A3, mode=10, mem_ready low 2 cycles per byte -> addr/data held during waits; writes 01FF<=80, 01FE<=00, 01FD<=A3 (or B3 with the macro and brk_in=1); sp_out=FC.
- SP wrap: sp_in=00, mode=01, pc_in=1234 -> writes 0100<=12, then 01FF<=34; sp_out=FE; address high byte stays 01.
- Reset mid-op: INT push, assert reset after the first accepted byte -> next cycle write_en=0, busy=0, sp_out=FD; no further writes.
- Ignored starts: mode=11 start -> no write_en and busy stays 0. Start pulses during a BYTE push with data_in changed -> exactly one write of the originally latched byte.
- Back-to-back: PHA (sp_in=FD, data_in=55) then a new start in the cycle after done -> second sequence begins with a one-cycle gap; done pulses exactly once per sequence.
